// File: rtl/hash_rs.sv
// hash_rs: reservation station feeding the hash functional unit.
// Buffers dispatched ops in a compacting age queue (index 0 = oldest) until
// both source operands are valid. Missing sources are captured from the CDB.
// The oldest ready op is issued to the FU with a registered one-cycle pulse.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                synchronous flush, discards every entry
//   dispatch_*           op handshake and payload from the dispatcher
//   cdb_valid/id/val     common data bus broadcast (wakeup source)
//   fu_busy              FU stall, blocks issue while high
//   input_transmit       one-cycle issue pulse to the FU
//   operand, depvals, wbs, flags, robid  registered issue payload
//   occupancy            number of valid entries
//
// Optional feature macro: HASH_RS_CDB_BYPASS_EN
//   When defined, select also treats a source being woken by the CDB in the
//   current cycle as ready, giving CDB-to-issue latency of one cycle.
module hash_rs #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  input  logic [7:0]                 dispatch_operand,
  input  logic [2*TAG_W-1:0]         dispatch_depids,
  input  logic [1:0]                 dispatch_depready,
  input  logic [2*DATA_W-1:0]        dispatch_depvals,
  input  logic [7:0]                 dispatch_wbs,
  input  logic [7:0]                 dispatch_flags,
  input  logic [TAG_W-1:0]           dispatch_robid,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_id,
  input  logic [DATA_W-1:0]          cdb_val,
  input  logic                       fu_busy,
  output logic                       input_transmit,
  output logic [7:0]                 operand,
  output logic [2*DATA_W-1:0]        depvals,
  output logic [7:0]                 wbs,
  output logic [7:0]                 flags,
  output logic [TAG_W-1:0]           robid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic                   valid;
    logic [1:0]             rdy;
    logic [1:0][TAG_W-1:0]  tag;
    logic [1:0][DATA_W-1:0] val;
    logic [7:0]             operand;
    logic [7:0]             wbs;
    logic [7:0]             flags;
    logic [TAG_W-1:0]       robid;
  } entry_t;

  entry_t ents  [DEPTH];
  entry_t woken [DEPTH];
  entry_t nxt   [DEPTH];
  entry_t new_ent;

  logic                   cand_found;
  int                     sel_idx;
  logic [7:0]             cand_operand;
  logic [1:0][DATA_W-1:0] cand_val;
  logic [7:0]             cand_wbs;
  logic [7:0]             cand_flags;
  logic [TAG_W-1:0]       cand_robid;

  logic             issue;
  logic             accept;
  logic [OCC_W-1:0] occ_after;
  logic [OCC_W-1:0] occ_next;
  logic             ready_next;

  // CDB wakeup applied to every waiting source of every valid entry
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      woken[i] = ents[i];
      for (int s = 0; s < 2; s++) begin
        if (ents[i].valid && !ents[i].rdy[s] && cdb_valid && (cdb_id == ents[i].tag[s])) begin
          woken[i].rdy[s] = 1'b1;
          woken[i].val[s] = cdb_val;
        end
      end
    end
  end

  // Oldest-ready select; scanning downward leaves the lowest index selected
  always_comb begin
    cand_found   = 1'b0;
    sel_idx      = 0;
    cand_operand = '0;
    cand_val     = '0;
    cand_wbs     = '0;
    cand_flags   = '0;
    cand_robid   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
`ifdef HASH_RS_CDB_BYPASS_EN
      if (woken[i].valid && (&woken[i].rdy)) begin
`else
      if (ents[i].valid && (&ents[i].rdy)) begin
`endif
        cand_found   = 1'b1;
        sel_idx      = i;
        cand_operand = woken[i].operand;
        cand_val     = woken[i].val;
        cand_wbs     = woken[i].wbs;
        cand_flags   = woken[i].flags;
        cand_robid   = woken[i].robid;
      end
    end
  end

  assign issue  = cand_found && !fu_busy;
  assign accept = dispatch_valid && dispatch_ready;

  // Incoming entry; a same-cycle CDB hit on a missing source is captured
  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.operand = dispatch_operand;
    new_ent.wbs     = dispatch_wbs;
    new_ent.flags   = dispatch_flags;
    new_ent.robid   = dispatch_robid;
    for (int s = 0; s < 2; s++) begin
      new_ent.tag[s] = dispatch_depids[s*TAG_W +: TAG_W];
      new_ent.val[s] = dispatch_depvals[s*DATA_W +: DATA_W];
      if (dispatch_depready[s]) begin
        new_ent.rdy[s] = 1'b1;
      end else if (cdb_valid && (cdb_id == new_ent.tag[s])) begin
        new_ent.rdy[s] = 1'b1;
        new_ent.val[s] = cdb_val;
      end
    end
  end

  // Compaction: entries above the issued slot shift down, then the new op
  // lands at the first free slot left after the shift
  always_comb begin
    occ_after = occupancy - OCC_W'(issue);
    occ_next  = occ_after + OCC_W'(accept);
    for (int i = 0; i < int'(DEPTH); i++) begin
      nxt[i] = woken[i];
    end
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if (issue && (i >= sel_idx)) begin
        nxt[i] = woken[i+1];
      end
    end
    if (issue) begin
      nxt[DEPTH-1] = '0;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (accept && (OCC_W'(i) == occ_after)) begin
        nxt[i] = new_ent;
      end
    end
    ready_next = (occ_next < OCC_W'(DEPTH));
  end

  // State and registered issue outputs; flush behaves exactly like reset
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ents[i] <= '0;
      end
      occupancy      <= '0;
      dispatch_ready <= 1'b1;
      input_transmit <= 1'b0;
      operand        <= '0;
      depvals        <= '0;
      wbs            <= '0;
      flags          <= '0;
      robid          <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ents[i] <= nxt[i];
      end
      occupancy      <= occ_next;
      dispatch_ready <= ready_next;
      input_transmit <= issue;
      if (issue) begin
        operand <= cand_operand;
        depvals <= cand_val;
        wbs     <= cand_wbs;
        flags   <= cand_flags;
        robid   <= cand_robid;
      end
    end
  end

endmodule

// File: tb/tb_hash_rs.sv
// tb_hash_rs: self-checking bench for hash_rs. A queue-level reference model
// predicts the registered outputs after every clock edge; directed scenarios
// add literal expectations, followed by a randomized phase.
module tb_hash_rs;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OCC_W  = $clog2(DEPTH+1);

  logic                clk;
  logic                rst;
  logic                flush;
  logic                dispatch_valid;
  logic                dispatch_ready;
  logic [7:0]          dispatch_operand;
  logic [2*TAG_W-1:0]  dispatch_depids;
  logic [1:0]          dispatch_depready;
  logic [2*DATA_W-1:0] dispatch_depvals;
  logic [7:0]          dispatch_wbs;
  logic [7:0]          dispatch_flags;
  logic [TAG_W-1:0]    dispatch_robid;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_id;
  logic [DATA_W-1:0]   cdb_val;
  logic                fu_busy;
  logic                input_transmit;
  logic [7:0]          operand;
  logic [2*DATA_W-1:0] depvals;
  logic [7:0]          wbs;
  logic [7:0]          flags;
  logic [TAG_W-1:0]    robid;
  logic [OCC_W-1:0]    occupancy;

  hash_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .dispatch_valid    (dispatch_valid),
    .dispatch_ready    (dispatch_ready),
    .dispatch_operand  (dispatch_operand),
    .dispatch_depids   (dispatch_depids),
    .dispatch_depready (dispatch_depready),
    .dispatch_depvals  (dispatch_depvals),
    .dispatch_wbs      (dispatch_wbs),
    .dispatch_flags    (dispatch_flags),
    .dispatch_robid    (dispatch_robid),
    .cdb_valid         (cdb_valid),
    .cdb_id            (cdb_id),
    .cdb_val           (cdb_val),
    .fu_busy           (fu_busy),
    .input_transmit    (input_transmit),
    .operand           (operand),
    .depvals           (depvals),
    .wbs               (wbs),
    .flags             (flags),
    .robid             (robid),
    .occupancy         (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of waiting ops, oldest at the front
  typedef struct {
    logic              rdy0;
    logic              rdy1;
    logic [TAG_W-1:0]  tag0;
    logic [TAG_W-1:0]  tag1;
    logic [DATA_W-1:0] val0;
    logic [DATA_W-1:0] val1;
    logic [7:0]        operand;
    logic [7:0]        wbs;
    logic [7:0]        flags;
    logic [TAG_W-1:0]  robid;
  } m_ent_t;

  m_ent_t q[$];

  logic                exp_tx;
  logic [7:0]          exp_operand;
  logic [2*DATA_W-1:0] exp_depvals;
  logic [7:0]          exp_wbs;
  logic [7:0]          exp_flags;
  logic [TAG_W-1:0]    exp_robid;
  logic [OCC_W-1:0]    exp_occ;
  logic                exp_ready;

  // Predict the state right after the coming clock edge from current inputs
  task automatic model_step();
    m_ent_t e;
    int     c;
    logic   acc;
    logic   r0;
    logic   r1;
    if (rst || flush) begin
      q.delete();
      exp_tx      = 1'b0;
      exp_operand = '0;
      exp_depvals = '0;
      exp_wbs     = '0;
      exp_flags   = '0;
      exp_robid   = '0;
    end else begin
      acc = dispatch_valid && (q.size() < int'(DEPTH));
      c = -1;
      for (int i = 0; i < q.size(); i++) begin
        r0 = q[i].rdy0;
        r1 = q[i].rdy1;
`ifdef HASH_RS_CDB_BYPASS_EN
        r0 = r0 || (cdb_valid && cdb_id == q[i].tag0);
        r1 = r1 || (cdb_valid && cdb_id == q[i].tag1);
`endif
        if (c < 0 && r0 && r1) c = i;
      end
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        if (!e.rdy0 && cdb_valid && cdb_id == e.tag0) begin e.rdy0 = 1'b1; e.val0 = cdb_val; end
        if (!e.rdy1 && cdb_valid && cdb_id == e.tag1) begin e.rdy1 = 1'b1; e.val1 = cdb_val; end
        q[i] = e;
      end
      if (c >= 0 && !fu_busy) begin
        exp_tx      = 1'b1;
        exp_operand = q[c].operand;
        exp_depvals = {q[c].val1, q[c].val0};
        exp_wbs     = q[c].wbs;
        exp_flags   = q[c].flags;
        exp_robid   = q[c].robid;
        q.delete(c);
      end else begin
        exp_tx = 1'b0;
      end
      if (acc) begin
        e.tag0    = dispatch_depids[TAG_W-1:0];
        e.tag1    = dispatch_depids[2*TAG_W-1:TAG_W];
        e.val0    = dispatch_depvals[DATA_W-1:0];
        e.val1    = dispatch_depvals[2*DATA_W-1:DATA_W];
        e.rdy0    = dispatch_depready[0];
        e.rdy1    = dispatch_depready[1];
        if (!e.rdy0 && cdb_valid && cdb_id == e.tag0) begin e.rdy0 = 1'b1; e.val0 = cdb_val; end
        if (!e.rdy1 && cdb_valid && cdb_id == e.tag1) begin e.rdy1 = 1'b1; e.val1 = cdb_val; end
        e.operand = dispatch_operand;
        e.wbs     = dispatch_wbs;
        e.flags   = dispatch_flags;
        e.robid   = dispatch_robid;
        q.push_back(e);
      end
    end
    exp_occ   = OCC_W'(q.size());
    exp_ready = (q.size() < int'(DEPTH));
  endtask

  // Compare DUT outputs against the model shortly after every edge
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("transmit",  32'(input_transmit), 32'(exp_tx));
      chk("operand",   32'(operand),        32'(exp_operand));
      chk("depvals",   32'(depvals),        32'(exp_depvals));
      chk("wbs",       32'(wbs),            32'(exp_wbs));
      chk("flags",     32'(flags),          32'(exp_flags));
      chk("robid",     32'(robid),          32'(exp_robid));
      chk("occupancy", 32'(occupancy),      32'(exp_occ));
      chk("disp_rdy",  32'(dispatch_ready), 32'(exp_ready));
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    #3;
  endtask

  task automatic disp(input logic v, input logic [TAG_W-1:0] rid, input logic [1:0] dr,
                      input logic [TAG_W-1:0] id0, input logic [DATA_W-1:0] v0,
                      input logic [TAG_W-1:0] id1, input logic [DATA_W-1:0] v1);
    dispatch_valid    = v;
    dispatch_robid    = rid;
    dispatch_depready = dr;
    dispatch_depids   = {id1, id0};
    dispatch_depvals  = {v1, v0};
    dispatch_operand  = 8'h40 + 8'(rid);
    dispatch_wbs      = 8'h10 + 8'(rid);
    dispatch_flags    = 8'h80 | 8'(rid);
  endtask

  task automatic cdb(input logic v, input logic [TAG_W-1:0] id, input logic [DATA_W-1:0] val);
    cdb_valid = v;
    cdb_id    = id;
    cdb_val   = val;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    fu_busy = 1'b0;
    disp(1'b1, 4'd3, 2'b11, 4'd0, 8'h34, 4'd0, 8'h12);
    cdb(1'b0, '0, '0);
    chk_en = 1'b1;

    // Reset with dispatch_valid held high
    tick();
    tick();
    chk("rst_occ",     32'(occupancy),      32'd0);
    chk("rst_ready",   32'(dispatch_ready), 32'd1);
    chk("rst_tx",      32'(input_transmit), 32'd0);
    chk("rst_robid",   32'(robid),          32'd0);
    chk("rst_depvals", 32'(depvals),        32'd0);
    chk("rst_operand", 32'(operand),        32'd0);

    // Ready dispatch issues one cycle after the accept edge
    rst = 1'b0;
    tick();
    chk("rdy_occ1", 32'(occupancy),      32'd1);
    chk("rdy_tx0",  32'(input_transmit), 32'd0);
    disp(1'b0, '0, 2'b00, '0, '0, '0, '0);
    tick();
    chk("rdy_tx",       32'(input_transmit), 32'd1);
    chk("rdy_robid",    32'(robid),          32'd3);
    chk("rdy_depvals",  32'(depvals),        32'h1234);
    chk("rdy_occ0",     32'(occupancy),      32'd0);
    chk("rdy_model_rb", 32'(exp_robid),      32'd3);
    tick();
    chk("rdy_tx_once",  32'(input_transmit), 32'd0);

    // CDB wakeup and age order
    disp(1'b1, 4'd1, 2'b10, 4'd5, 8'h00, 4'd0, 8'h11);
    tick();
    disp(1'b1, 4'd2, 2'b11, 4'd0, 8'h33, 4'd0, 8'h22);
    tick();
    disp(1'b0, '0, 2'b00, '0, '0, '0, '0);
    tick();
    chk("age_b_tx",    32'(input_transmit), 32'd1);
    chk("age_b_robid", 32'(robid),          32'd2);
    chk("age_occ1",    32'(occupancy),      32'd1);
    cdb(1'b1, 4'd5, 8'hAA);
    tick();
    cdb(1'b0, '0, '0);
`ifdef HASH_RS_CDB_BYPASS_EN
    chk("wake_a_tx",      32'(input_transmit), 32'd1);
    chk("wake_a_robid",   32'(robid),          32'd1);
    chk("wake_a_depvals", 32'(depvals),        32'h11AA);
    tick();
    chk("wake_after_tx",  32'(input_transmit), 32'd0);
`else
    chk("wake_t1_tx",     32'(input_transmit), 32'd0);
    chk("wake_t1_occ",    32'(occupancy),      32'd1);
    tick();
    chk("wake_a_tx",      32'(input_transmit), 32'd1);
    chk("wake_a_robid",   32'(robid),          32'd1);
    chk("wake_a_depvals", 32'(depvals),        32'h11AA);
    chk("wake_model_dv",  32'(exp_depvals),    32'h11AA);
`endif
    chk("wake_occ0", 32'(occupancy), 32'd0);

    // Fill under stall, reject the fifth op, drain in dispatch order
    fu_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      disp(1'b1, TAG_W'(4 + k), 2'b11, 4'd0, 8'(k), 4'd0, 8'(8'h80 + k));
      tick();
    end
    chk("full_occ",   32'(occupancy),      32'd4);
    chk("full_ready", 32'(dispatch_ready), 32'd0);
    disp(1'b1, 4'd8, 2'b11, 4'd0, 8'hEE, 4'd0, 8'hEE);
    tick();
    chk("full_reject_occ", 32'(occupancy), 32'd4);
    disp(1'b0, '0, 2'b00, '0, '0, '0, '0);
    fu_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_tx",    32'(input_transmit), 32'd1);
      chk("drain_robid", 32'(robid),          32'(4 + k));
    end
    tick();
    chk("drain_done_tx", 32'(input_transmit), 32'd0);
    chk("drain_occ",     32'(occupancy),      32'd0);

    // Same-cycle dispatch capture of a CDB value
    disp(1'b1, 4'd9, 2'b10, 4'd7, 8'h00, 4'd0, 8'h01);
    cdb(1'b1, 4'd7, 8'h5C);
    tick();
    chk("cap_occ", 32'(occupancy), 32'd1);
    disp(1'b0, '0, 2'b00, '0, '0, '0, '0);
    cdb(1'b0, '0, '0);
    tick();
    chk("cap_tx",      32'(input_transmit), 32'd1);
    chk("cap_robid",   32'(robid),          32'd9);
    chk("cap_depvals", 32'(depvals),        32'h015C);

    // Flush wins over dispatch, issue and CDB capture
    for (int k = 0; k < 3; k++) begin
      disp(1'b1, TAG_W'(10 + k), 2'b10, 4'd3, 8'h00, 4'd0, 8'(8'h20 + k));
      tick();
    end
    chk("fl_occ3", 32'(occupancy), 32'd3);
    flush = 1'b1;
    disp(1'b1, 4'd13, 2'b11, 4'd0, 8'h01, 4'd0, 8'h02);
    cdb(1'b1, 4'd3, 8'h77);
    tick();
    chk("fl_occ",     32'(occupancy),      32'd0);
    chk("fl_tx",      32'(input_transmit), 32'd0);
    chk("fl_robid",   32'(robid),          32'd0);
    chk("fl_depvals", 32'(depvals),        32'd0);
    flush = 1'b0;
    disp(1'b0, '0, 2'b00, '0, '0, '0, '0);
    tick();
    chk("fl_late_tx",  32'(input_transmit), 32'd0);
    cdb(1'b0, '0, '0);
    tick();
    chk("fl_late_tx2", 32'(input_transmit), 32'd0);
    chk("fl_late_occ", 32'(occupancy),      32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 99) == 0);
      disp(($urandom_range(0, 9) < 6), TAG_W'($urandom), 2'($urandom),
           TAG_W'($urandom_range(0, 3)), DATA_W'($urandom),
           TAG_W'($urandom_range(0, 3)), DATA_W'($urandom));
      dispatch_operand = 8'($urandom);
      if ($urandom_range(0, 9) < 4)
        cdb(1'b1, TAG_W'($urandom_range(0, 4)), DATA_W'($urandom));
      else
        cdb(1'b0, TAG_W'($urandom), DATA_W'($urandom));
      fu_busy = ($urandom_range(0, 9) < 3);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
